// File: rtl/icache_refill_unit.sv
// Line-refill engine for the L1 instruction cache.
// On a miss it issues one burst read for the line and streams the returned words
// into the cache with their offsets. A redirect abort drains the rest of the burst.
//
// state | meaning
// IDLE  | waiting for a miss while replacement is permitted
// REQ   | burst request presented, waiting for memory to accept it
// FILL  | receiving beats and writing them into the L1 line
// DRAIN | aborted after acceptance; swallowing the remaining beats
// DONE  | line complete; one-cycle RepBlockDone pulse
module icache_refill_unit #(
  parameter int B    = 16,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 InstrMissF,
  input  logic                 InstrCacheRepActive,
  input  logic                 RepAbort,
  input  logic [XLEN-1:0]      PCF,
  output logic                 MemReqValid,
  input  logic                 MemReqReady,
  output logic [XLEN-1:0]      MemReqAddr,
  input  logic                 MemRespValid,
  input  logic [XLEN-1:0]      MemRespData,
  output logic [XLEN-1:0]      RepWord,
  output logic [$clog2(B)-1:0] RepWordOffset,
  output logic                 RepWordValid,
  output logic                 RepBlockDone,
  output logic                 RepBusy
);

  localparam int LW = $clog2(B);
  localparam int AW = LW + 2;
  localparam int CW = LW + 1;
  // Clears the byte-in-word and word-in-line bits of the fetch address.
  localparam logic [XLEN-1:0] LINE_MASK = ~(XLEN'((1 << AW) - 1));

  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          start;
  logic          last_beat;

  assign start     = InstrMissF & InstrCacheRepActive & ~RepAbort;
  // The beat that brings the count to B ends the burst, whether filling or draining.
  assign last_beat = MemRespValid && (cnt == CW'(B - 1));

  // Next-state and beat counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) state_nxt = REQ;
      end
      REQ: begin
        if (MemReqReady) begin
          cnt_nxt   = '0;
          // An abort coinciding with acceptance still leaves a burst in flight.
          state_nxt = RepAbort ? DRAIN : FILL;
        end else if (RepAbort) begin
          state_nxt = IDLE;
        end
      end
      FILL: begin
        if (MemRespValid) cnt_nxt = cnt + 1'b1;
        if (RepAbort) begin
          // If the abort lands on the final beat there is nothing left to drain.
          state_nxt = last_beat ? IDLE : DRAIN;
        end else if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DRAIN: begin
        if (MemRespValid) cnt_nxt = cnt + 1'b1;
        if (last_beat) state_nxt = IDLE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Line address captured once on leaving IDLE so later PCF changes cannot disturb the refill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MemReqAddr <= '0;
    end else if (state == IDLE && start) begin
      MemReqAddr <= PCF & LINE_MASK;
    end
  end

  // Registered write port: one cycle after each accepted beat in FILL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RepWord       <= '0;
      RepWordOffset <= '0;
      RepWordValid  <= 1'b0;
    end else begin
      RepWordValid <= (state == FILL) && MemRespValid && !RepAbort;
      if ((state == FILL) && MemRespValid && !RepAbort) begin
        RepWord       <= MemRespData;
        RepWordOffset <= cnt[LW-1:0];
      end
    end
  end

  assign MemReqValid  = (state == REQ);
  assign RepBusy      = (state != IDLE);
  // DONE follows the last FILL beat, so this lines up with the final registered write.
  assign RepBlockDone = (state == DONE);

  // Responses are only legal while a burst is outstanding.
  a_resp_in_burst: assert property (@(posedge clk) disable iff (!reset)
    MemRespValid |-> (state == FILL || state == DRAIN));

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: full line, gapped responses, aborts,
// ignored misses and asynchronous reset mid-burst.
module tb_icache_refill_unit;

  localparam int B    = 16;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            InstrMissF = 1'b0;
  logic            InstrCacheRepActive = 1'b0;
  logic            RepAbort = 1'b0;
  logic [XLEN-1:0] PCF = '0;
  logic            MemReqValid;
  logic            MemReqReady = 1'b0;
  logic [XLEN-1:0] MemReqAddr;
  logic            MemRespValid = 1'b0;
  logic [XLEN-1:0] MemRespData = '0;
  logic [XLEN-1:0] RepWord;
  logic [3:0]      RepWordOffset;
  logic            RepWordValid;
  logic            RepBlockDone;
  logic            RepBusy;

  int checks = 0;
  int errors = 0;

  icache_refill_unit #(.B(B), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .InstrMissF(InstrMissF), .InstrCacheRepActive(InstrCacheRepActive),
    .RepAbort(RepAbort), .PCF(PCF),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemReqAddr(MemReqAddr),
    .MemRespValid(MemRespValid), .MemRespData(MemRespData),
    .RepWord(RepWord), .RepWordOffset(RepWordOffset), .RepWordValid(RepWordValid),
    .RepBlockDone(RepBlockDone), .RepBusy(RepBusy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  // One-cycle miss pulse; DUT is in REQ when this returns.
  task automatic start_miss(input logic [XLEN-1:0] pc);
    InstrMissF = 1'b1; InstrCacheRepActive = 1'b1; PCF = pc;
    cyc();
    InstrMissF = 1'b0; InstrCacheRepActive = 1'b0;
  endtask

  // Accept the request; DUT is in FILL when this returns.
  task automatic accept_req();
    MemReqReady = 1'b1;
    cyc();
    MemReqReady = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    checks++;
    if ({MemReqValid, RepWordValid, RepBlockDone, RepBusy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b required 0000", {MemReqValid, RepWordValid, RepBlockDone, RepBusy});
    end
    checks++;
    if (MemReqAddr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h required 00000000", MemReqAddr);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_full_line();
    int blk_pulses = 0;
    start_miss(32'h0000_1234);
    checks++;
    if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h0000_1200) begin
      errors++; $display("FAIL full_req: valid %b addr %h required 1 00001200", MemReqValid, MemReqAddr);
    end
    PCF = 32'hFFFF_0000;
    accept_req();
    checks++;
    if (MemReqValid !== 1'b0 || RepBusy !== 1'b1 || MemReqAddr !== 32'h0000_1200) begin
      errors++; $display("FAIL full_fill_entry: valid %b busy %b addr %h required 0 1 00001200", MemReqValid, RepBusy, MemReqAddr);
    end
    for (int i = 0; i < B; i++) begin
      MemRespValid = 1'b1; MemRespData = 32'hA000_0000 + i;
      cyc();
      checks++;
      if (RepWordValid !== 1'b1 || RepWordOffset !== 4'(i) || RepWord !== 32'hA000_0000 + i) begin
        errors++; $display("FAIL full_beat%0d: v %b off %0d data %h required 1 %0d %h", i, RepWordValid, RepWordOffset, RepWord, i, 32'hA000_0000 + i);
      end
      if (RepBlockDone === 1'b1) blk_pulses++;
      checks++;
      if (RepBlockDone !== (i == B - 1)) begin
        errors++; $display("FAIL full_done%0d: got %b required %b", i, RepBlockDone, (i == B - 1));
      end
    end
    MemRespValid = 1'b0;
    cyc();
    if (RepBlockDone === 1'b1) blk_pulses++;
    checks++;
    if (blk_pulses != 1 || RepBusy !== 1'b0 || RepWordValid !== 1'b0) begin
      errors++; $display("FAIL full_end: pulses %0d busy %b v %b required 1 0 0", blk_pulses, RepBusy, RepWordValid);
    end
  endtask

  task automatic test_gaps();
    start_miss(32'h0000_4010);
    checks++;
    if (MemReqAddr !== 32'h0000_4000) begin
      errors++; $display("FAIL gap_addr: got %h required 00004000", MemReqAddr);
    end
    accept_req();
    for (int i = 0; i < B; i++) begin
      int gap = $urandom_range(0, 3);
      MemRespValid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        cyc();
        checks++;
        if (RepWordValid !== 1'b0 || RepBusy !== 1'b1) begin
          errors++; $display("FAIL gap_idle%0d: v %b busy %b required 0 1", i, RepWordValid, RepBusy);
        end
      end
      MemRespValid = 1'b1; MemRespData = 32'h5500_0000 ^ (i * 32'h0101);
      cyc();
      checks++;
      if (RepWordValid !== 1'b1 || RepWordOffset !== 4'(i) || RepWord !== (32'h5500_0000 ^ (i * 32'h0101)) || RepBusy !== 1'b1) begin
        errors++; $display("FAIL gap_beat%0d: v %b off %0d data %h busy %b required 1 %0d %h 1", i, RepWordValid, RepWordOffset, RepWord, RepBusy, i, 32'h5500_0000 ^ (i * 32'h0101));
      end
    end
    MemRespValid = 1'b0;
    cyc();
    checks++;
    if (RepBusy !== 1'b0) begin
      errors++; $display("FAIL gap_end: busy %b required 0", RepBusy);
    end
  endtask

  task automatic test_abort_req();
    start_miss(32'h0000_8000);
    RepAbort = 1'b1;
    cyc();
    RepAbort = 1'b0;
    checks++;
    if (MemReqValid !== 1'b0 || RepBusy !== 1'b0) begin
      errors++; $display("FAIL abort_req: valid %b busy %b required 0 0", MemReqValid, RepBusy);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (MemReqValid !== 1'b0 || RepWordValid !== 1'b0) begin
        errors++; $display("FAIL abort_req_quiet%0d: valid %b v %b required 0 0", i, MemReqValid, RepWordValid);
      end
    end
  endtask

  task automatic test_abort_fill();
    start_miss(32'h0000_9000);
    accept_req();
    for (int i = 0; i < 5; i++) begin
      MemRespValid = 1'b1; MemRespData = 32'hC0DE_0000 + i;
      cyc();
      checks++;
      if (RepWordValid !== 1'b1 || RepWordOffset !== 4'(i)) begin
        errors++; $display("FAIL abortf_beat%0d: v %b off %0d required 1 %0d", i, RepWordValid, RepWordOffset, i);
      end
    end
    // Beat 5 arrives in the abort cycle: counted, not written.
    MemRespData = 32'hC0DE_0005; RepAbort = 1'b1;
    cyc();
    RepAbort = 1'b0;
    checks++;
    if (RepWordValid !== 1'b0 || RepBusy !== 1'b1) begin
      errors++; $display("FAIL abortf_cut: v %b busy %b required 0 1", RepWordValid, RepBusy);
    end
    for (int i = 6; i < B; i++) begin
      MemRespData = 32'hC0DE_0000 + i;
      cyc();
      checks++;
      if (RepWordValid !== 1'b0 || RepBlockDone !== 1'b0 || RepBusy !== (i != B - 1)) begin
        errors++; $display("FAIL abortf_drain%0d: v %b done %b busy %b required 0 0 %b", i, RepWordValid, RepBlockDone, RepBusy, (i != B - 1));
      end
    end
    MemRespValid = 1'b0;
    cyc();
    checks++;
    if (RepBusy !== 1'b0 || RepBlockDone !== 1'b0) begin
      errors++; $display("FAIL abortf_end: busy %b done %b required 0 0", RepBusy, RepBlockDone);
    end
  endtask

  task automatic test_ignored_miss();
    InstrMissF = 1'b1; InstrCacheRepActive = 1'b0; PCF = 32'h0000_7000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (MemReqValid !== 1'b0 || RepBusy !== 1'b0) begin
        errors++; $display("FAIL inactive%0d: valid %b busy %b required 0 0", i, MemReqValid, RepBusy);
      end
    end
    InstrMissF = 1'b0;
    start_miss(32'h0000_2000);
    accept_req();
    // Keep a second miss asserted for the whole burst.
    InstrMissF = 1'b1; InstrCacheRepActive = 1'b1; PCF = 32'h0000_8888;
    for (int i = 0; i < B; i++) begin
      MemRespValid = 1'b1; MemRespData = 32'h1111_0000 + i;
      cyc();
      checks++;
      if (MemReqValid !== 1'b0 || RepWordOffset !== 4'(i) || MemReqAddr !== 32'h0000_2000) begin
        errors++; $display("FAIL busy_miss%0d: valid %b off %0d addr %h required 0 %0d 00002000", i, MemReqValid, RepWordOffset, MemReqAddr, i);
      end
    end
    MemRespValid = 1'b0;
    cyc();
    checks++;
    if (RepBusy !== 1'b0 || MemReqValid !== 1'b0) begin
      errors++; $display("FAIL busy_gap: busy %b valid %b required 0 0", RepBusy, MemReqValid);
    end
    cyc();
    checks++;
    if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h0000_8880) begin
      errors++; $display("FAIL busy_next_req: valid %b addr %h required 1 00008880", MemReqValid, MemReqAddr);
    end
    InstrMissF = 1'b0; InstrCacheRepActive = 1'b0; RepAbort = 1'b1;
    cyc();
    RepAbort = 1'b0;
  endtask

  task automatic test_async_reset();
    start_miss(32'h0000_5000);
    accept_req();
    for (int i = 0; i < 3; i++) begin
      MemRespValid = 1'b1; MemRespData = 32'hBEEF_0000 + i;
      cyc();
    end
    MemRespValid = 1'b0;
    checks++;
    if (RepWordValid !== 1'b1 || RepBusy !== 1'b1) begin
      errors++; $display("FAIL areset_pre: v %b busy %b required 1 1", RepWordValid, RepBusy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({MemReqValid, RepWordValid, RepBlockDone, RepBusy} !== 4'b0000 || MemReqAddr !== 32'h0 || RepWord !== 32'h0) begin
      errors++; $display("FAIL areset_now: flags %b addr %h word %h required 0000 0 0", {MemReqValid, RepWordValid, RepBlockDone, RepBusy}, MemReqAddr, RepWord);
    end
    cyc();
    reset = 1'b1;
    cyc();
    start_miss(32'h0000_307C);
    checks++;
    if (MemReqValid !== 1'b1 || MemReqAddr !== 32'h0000_3040) begin
      errors++; $display("FAIL areset_req: valid %b addr %h required 1 00003040", MemReqValid, MemReqAddr);
    end
    accept_req();
    for (int i = 0; i < B; i++) begin
      MemRespValid = 1'b1; MemRespData = 32'h7700_0000 + i;
      cyc();
      checks++;
      if (RepWordValid !== 1'b1 || RepWordOffset !== 4'(i) || RepWord !== 32'h7700_0000 + i || RepBlockDone !== (i == B - 1)) begin
        errors++; $display("FAIL areset_beat%0d: v %b off %0d data %h done %b required 1 %0d %h %b", i, RepWordValid, RepWordOffset, RepWord, RepBlockDone, i, 32'h7700_0000 + i, (i == B - 1));
      end
    end
    MemRespValid = 1'b0;
    cyc();
    checks++;
    if (RepBusy !== 1'b0) begin
      errors++; $display("FAIL areset_end: busy %b required 0", RepBusy);
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_gaps();
    test_abort_req();
    test_abort_fill();
    test_ignored_miss();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
